// File: rtl/data_ram_bridge_if.sv
// rtl/data_ram_bridge_if.sv - core request/response and data RAM signal bundle for data_ram_bridge
interface data_ram_bridge_if #(
    parameter int ADDR_WIDTH = 16
);
    // Core side: request, grant and response
    logic                  data_req_i;
    logic                  data_gnt_o;
    logic [31:0]           data_addr_i;
    logic                  data_we_i;
    logic [1:0]            data_size_i;
    logic                  data_sign_i;
    logic [31:0]           data_wdata_i;
    logic                  data_rvalid_o;
    logic [31:0]           data_rdata_o;
    logic                  data_err_o;

    // RAM side: single-port, registered read
    logic                  ram_en_o;
    logic                  ram_we_o;
    logic [ADDR_WIDTH-1:0] ram_addr_o;
    logic [3:0]            ram_be_o;
    logic [31:0]           ram_wdata_o;
    logic [31:0]           ram_rdata_i;

    // Environment view: the core and the RAM around the bridge
    modport master (
        output data_req_i,
        output data_addr_i,
        output data_we_i,
        output data_size_i,
        output data_sign_i,
        output data_wdata_i,
        input  data_gnt_o,
        input  data_rvalid_o,
        input  data_rdata_o,
        input  data_err_o,
        input  ram_en_o,
        input  ram_we_o,
        input  ram_addr_o,
        input  ram_be_o,
        input  ram_wdata_o,
        output ram_rdata_i
    );

    // Bridge view
    modport slave (
        input  data_req_i,
        input  data_addr_i,
        input  data_we_i,
        input  data_size_i,
        input  data_sign_i,
        input  data_wdata_i,
        output data_gnt_o,
        output data_rvalid_o,
        output data_rdata_o,
        output data_err_o,
        output ram_en_o,
        output ram_we_o,
        output ram_addr_o,
        output ram_be_o,
        output ram_wdata_o,
        input  ram_rdata_i
    );
endinterface

// File: rtl/data_ram_bridge.sv
// rtl/data_ram_bridge.sv - LSU front end for the single-port data RAM (optional DATA_RAM_BRIDGE_RANGE_CHECK_EN)
module data_ram_bridge #(
    parameter int ADDR_WIDTH = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    data_ram_bridge_if.slave  bus
);
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_SECOND = 1'b1;

    logic [0:0]            state_q;

    // Request decode (valid on the grant cycle only)
    logic [1:0]            req_off;
    logic                  req_is_half;
    logic                  req_is_word;
    logic [3:0]            req_mask;
    logic [7:0]            req_be_wide;
    logic [63:0]           req_wdata_wide;
    logic                  req_misaligned;
    logic                  req_range_err;
    logic [ADDR_WIDTH-3:0] req_word_idx;
    logic [ADDR_WIDTH-3:0] req_next_word_idx;

    logic                  grant;
    logic                  first_en;
    logic                  second_en;

    // State carried from the grant cycle to the second RAM cycle / response cycle
    logic [1:0]            off_q;
    logic [1:0]            size_q;
    logic                  sign_q;
    logic                  we_q;
    logic                  mis_q;
    logic [3:0]            be_hi_q;
    logic [31:0]           wdata_hi_q;
    logic [ADDR_WIDTH-3:0] word_hi_q;
    logic [31:0]           lo_data_q;

    logic                  rsp_valid_q;
    logic                  rsp_err_q;

    // Response datapath
    logic [63:0]           rsp_merged;
    logic [31:0]           rsp_word;
    logic [31:0]           rsp_ext;

    // Decode size/offset into lane mask, lane-shifted data and misalignment
    always_comb begin
        req_off           = bus.data_addr_i[1:0];
        req_is_word       = bus.data_size_i[1];
        req_is_half       = (bus.data_size_i == 2'b01);
        req_mask          = req_is_word ? 4'b1111 : (req_is_half ? 4'b0011 : 4'b0001);
        req_be_wide       = {4'b0000, req_mask} << req_off;
        req_wdata_wide    = {32'h0, bus.data_wdata_i} << {req_off, 3'b000};
        req_misaligned    = (req_is_half && (req_off == 2'd3)) ||
                            (req_is_word && (req_off != 2'd0));
        req_word_idx      = bus.data_addr_i[ADDR_WIDTH-1:2];
        req_next_word_idx = req_word_idx + 1'b1;
    end

`ifdef DATA_RAM_BRIDGE_RANGE_CHECK_EN
    // Out-of-range: address bits above the RAM, or a split access running off the top
    always_comb begin
        req_range_err = ((bus.data_addr_i >> ADDR_WIDTH) != 32'h0) ||
                        (req_misaligned && (&req_word_idx));
    end
`else
    // Upper address bits alias onto the RAM and split accesses wrap to word 0
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.data_addr_i[31:ADDR_WIDTH];
    always_comb begin
        req_range_err = 1'b0;
    end
`endif

    // Grant only when idle; reset masks both grant and any RAM cycle
    always_comb begin
        grant     = bus.data_req_i && (state_q == ST_IDLE) && !rst_i;
        first_en  = grant && !req_range_err;
        second_en = (state_q == ST_SECOND) && !rst_i;
        bus.data_gnt_o = grant;
    end

    // Drive the RAM port: first word on grant, upper word in SECOND, all-zero otherwise
    always_comb begin
        bus.ram_en_o    = 1'b0;
        bus.ram_we_o    = 1'b0;
        bus.ram_addr_o  = '0;
        bus.ram_be_o    = 4'b0000;
        bus.ram_wdata_o = 32'h0;
        if (second_en) begin
            bus.ram_en_o    = 1'b1;
            bus.ram_we_o    = we_q;
            bus.ram_addr_o  = {word_hi_q, 2'b00};
            bus.ram_be_o    = be_hi_q;
            bus.ram_wdata_o = wdata_hi_q;
        end else if (first_en) begin
            bus.ram_en_o    = 1'b1;
            bus.ram_we_o    = bus.data_we_i;
            bus.ram_addr_o  = {req_word_idx, 2'b00};
            bus.ram_be_o    = req_be_wide[3:0];
            bus.ram_wdata_o = req_wdata_wide[31:0];
        end
    end

    // Control FSM and response pulse; reset in SECOND abandons the second half silently
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (grant) begin
                        if (req_range_err) begin
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                        end else if (req_misaligned) begin
                            state_q <= ST_SECOND;
                        end else begin
                            rsp_valid_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    rsp_valid_q <= 1'b1;
                end
            endcase
        end
    end

    // Capture transaction attributes on grant and the low read word during SECOND
    always_ff @(posedge clk_i) begin
        if (grant) begin
            off_q      <= req_off;
            size_q     <= bus.data_size_i;
            sign_q     <= bus.data_sign_i;
            we_q       <= bus.data_we_i;
            mis_q      <= req_misaligned && !req_range_err;
            be_hi_q    <= req_be_wide[7:4];
            wdata_hi_q <= req_wdata_wide[63:32];
            word_hi_q  <= req_next_word_idx;
        end
        if (second_en) begin
            lo_data_q <= bus.ram_rdata_i;
        end
    end

    // Merge the two words, shift the addressed byte to lane 0 and extend to 32 bits
    always_comb begin
        rsp_merged = mis_q ? {bus.ram_rdata_i, lo_data_q} : {32'h0, bus.ram_rdata_i};
        rsp_word   = 32'(rsp_merged >> {off_q, 3'b000});
        case (size_q)
            2'b00:   rsp_ext = sign_q ? {{24{rsp_word[7]}},  rsp_word[7:0]}
                                      : {24'h0, rsp_word[7:0]};
            2'b01:   rsp_ext = sign_q ? {{16{rsp_word[15]}}, rsp_word[15:0]}
                                      : {16'h0, rsp_word[15:0]};
            default: rsp_ext = rsp_word;
        endcase
    end

    // Response outputs: data only for successful loads, zero otherwise
    always_comb begin
        bus.data_rvalid_o = rsp_valid_q;
        bus.data_err_o    = rsp_err_q;
        bus.data_rdata_o  = (rsp_valid_q && !we_q && !rsp_err_q) ? rsp_ext : 32'h0;
    end
endmodule

// File: tb/tb_data_ram_bridge.sv
// tb/tb_data_ram_bridge.sv - directed table-driven bench for data_ram_bridge with a behavioural RAM
module tb_data_ram_bridge;
    localparam int AW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_clr = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;

    data_ram_bridge_if #(.ADDR_WIDTH(AW)) bus ();

    data_ram_bridge #(.ADDR_WIDTH(AW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Single-port RAM, byte-enabled writes, registered read
    logic [31:0] mem [0:(1<<(AW-2))-1];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < (1 << (AW - 2)); i++) mem[i] <= 32'h0;
        end else if (bus.ram_en_o) begin
            if (bus.ram_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (bus.ram_be_o[b]) mem[bus.ram_addr_o[AW-1:2]][8*b +: 8] <= bus.ram_wdata_o[8*b +: 8];
            end else begin
                bus.ram_rdata_i <= mem[bus.ram_addr_o[AW-1:2]];
            end
        end
    end

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        sign;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        logic [31:0] exp_addr1;
        logic [3:0]  exp_be1;
        logic [31:0] exp_wd1;
        logic [31:0] exp_addr2;
        logic [3:0]  exp_be2;
        logic [31:0] exp_wd2;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic req, input logic we, input logic [31:0] addr,
                         input logic [1:0] size, input logic sign, input logic [31:0] wdata);
        bus.data_req_i   = req;
        bus.data_we_i    = we;
        bus.data_addr_i  = addr;
        bus.data_size_i  = size;
        bus.data_sign_i  = sign;
        bus.data_wdata_i = wdata;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int    cyc;
        int    lat;
        int    n_rv;
        logic [31:0] rd;
        logic  er;
        string t;
        t = $sformatf("v%0d", idx);
        @(posedge clk); #1;
        drive(1'b1, v.we, v.addr, v.size, v.sign, v.wdata);
        @(negedge clk);
        cyc = 0;
        while (!bus.data_gnt_o && cyc < 8) begin
            @(negedge clk);
            cyc++;
        end
        chk({t, ".gnt"},   32'(bus.data_gnt_o), 32'd1);
        chk({t, ".en1"},   32'(bus.ram_en_o), 32'(!v.exp_err));
        chk({t, ".we1"},   32'(bus.ram_we_o), 32'(v.we && !v.exp_err));
        chk({t, ".addr1"}, 32'(bus.ram_addr_o), v.exp_addr1);
        chk({t, ".be1"},   32'(bus.ram_be_o), 32'(v.exp_be1));
        chk({t, ".wd1"},   bus.ram_wdata_o, v.exp_wd1);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0);
        lat = 0; n_rv = 0; rd = 32'h0; er = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chk({t, ".en2"},   32'(bus.ram_en_o), 32'(v.exp_lat == 2));
                chk({t, ".we2"},   32'(bus.ram_we_o), 32'(v.we && v.exp_lat == 2));
                chk({t, ".addr2"}, 32'(bus.ram_addr_o), v.exp_addr2);
                chk({t, ".be2"},   32'(bus.ram_be_o), 32'(v.exp_be2));
                chk({t, ".wd2"},   bus.ram_wdata_o, v.exp_wd2);
            end
            if (bus.data_rvalid_o) begin
                n_rv++;
                if (n_rv == 1) begin
                    lat = k; rd = bus.data_rdata_o; er = bus.data_err_o;
                end
            end
        end
        chk({t, ".nrvalid"}, 32'(n_rv), 32'd1);
        chk({t, ".lat"},     32'(lat), 32'(v.exp_lat));
        chk({t, ".rdata"},   rd, v.exp_rdata);
        chk({t, ".err"},     32'(er), 32'(v.exp_err));
    endtask

    initial begin
        //            we    addr           sz    sg    wdata          rdata          err   lat addr1        be1     wd1            addr2        be2     wd2
        vecs[0]  = '{1'b1, 32'h0000_0010, 2'd2, 1'b0, 32'hDEADBEEF, 32'h0,         1'b0, 1, 32'h10,      4'b1111, 32'hDEADBEEF, 32'h0,       4'b0000, 32'h0};
        vecs[1]  = '{1'b0, 32'h0000_0010, 2'd2, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0, 1, 32'h10,      4'b1111, 32'h0,        32'h0,       4'b0000, 32'h0};
        vecs[2]  = '{1'b0, 32'h0000_0013, 2'd0, 1'b1, 32'h0,        32'hFFFFFFDE, 1'b0, 1, 32'h10,      4'b1000, 32'h0,        32'h0,       4'b0000, 32'h0};
        vecs[3]  = '{1'b0, 32'h0000_0013, 2'd0, 1'b0, 32'h0,        32'h000000DE, 1'b0, 1, 32'h10,      4'b1000, 32'h0,        32'h0,       4'b0000, 32'h0};
        vecs[4]  = '{1'b0, 32'h0000_0012, 2'd1, 1'b1, 32'h0,        32'hFFFFDEAD, 1'b0, 1, 32'h10,      4'b1100, 32'h0,        32'h0,       4'b0000, 32'h0};
        vecs[5]  = '{1'b0, 32'h0000_0010, 2'd1, 1'b0, 32'h0,        32'h0000BEEF, 1'b0, 1, 32'h10,      4'b0011, 32'h0,        32'h0,       4'b0000, 32'h0};
        vecs[6]  = '{1'b1, 32'h0000_0021, 2'd2, 1'b0, 32'h11223344, 32'h0,         1'b0, 2, 32'h20,      4'b1110, 32'h22334400, 32'h24,      4'b0001, 32'h00000011};
        vecs[7]  = '{1'b0, 32'h0000_0021, 2'd2, 1'b0, 32'h0,        32'h11223344, 1'b0, 2, 32'h20,      4'b1110, 32'h0,        32'h24,      4'b0001, 32'h0};
        vecs[8]  = '{1'b0, 32'h0000_0021, 2'd0, 1'b0, 32'h0,        32'h00000044, 1'b0, 1, 32'h20,      4'b0010, 32'h0,        32'h0,       4'b0000, 32'h0};
        vecs[9]  = '{1'b1, 32'h0000_0033, 2'd1, 1'b0, 32'h0000A5C3, 32'h0,         1'b0, 2, 32'h30,      4'b1000, 32'hC3000000, 32'h34,      4'b0001, 32'h000000A5};
        vecs[10] = '{1'b0, 32'h0000_0033, 2'd1, 1'b1, 32'h0,        32'hFFFFA5C3, 1'b0, 2, 32'h30,      4'b1000, 32'h0,        32'h34,      4'b0001, 32'h0};
        vecs[11] = '{1'b0, 32'h0000_0022, 2'd2, 1'b0, 32'h0,        32'h00112233, 1'b0, 2, 32'h20,      4'b1100, 32'h0,        32'h24,      4'b0011, 32'h0};
        vecs[12] = '{1'b1, 32'h0000_0012, 2'd0, 1'b0, 32'h0000007F, 32'h0,         1'b0, 1, 32'h10,      4'b0100, 32'h007F0000, 32'h0,       4'b0000, 32'h0};
        vecs[13] = '{1'b0, 32'h0000_0010, 2'd2, 1'b0, 32'h0,        32'hDE7FBEEF, 1'b0, 1, 32'h10,      4'b1111, 32'h0,        32'h0,       4'b0000, 32'h0};
        vecs[14] = '{1'b0, 32'h0000_0010, 2'd3, 1'b1, 32'h0,        32'hDE7FBEEF, 1'b0, 1, 32'h10,      4'b1111, 32'h0,        32'h0,       4'b0000, 32'h0};
`ifdef DATA_RAM_BRIDGE_RANGE_CHECK_EN
        vecs[15] = '{1'b1, 32'h0000_FFFF, 2'd2, 1'b0, 32'hCAFEF00D, 32'h0,         1'b1, 1, 32'h0,       4'b0000, 32'h0,        32'h0,       4'b0000, 32'h0};
        vecs[16] = '{1'b0, 32'h0000_FFFF, 2'd2, 1'b0, 32'h0,        32'h0,         1'b1, 1, 32'h0,       4'b0000, 32'h0,        32'h0,       4'b0000, 32'h0};
        vecs[17] = '{1'b0, 32'h0001_0000, 2'd2, 1'b0, 32'h0,        32'h0,         1'b1, 1, 32'h0,       4'b0000, 32'h0,        32'h0,       4'b0000, 32'h0};
`else
        vecs[15] = '{1'b1, 32'h0000_FFFF, 2'd2, 1'b0, 32'hCAFEF00D, 32'h0,         1'b0, 2, 32'hFFFC,    4'b1000, 32'h0D000000, 32'h0,       4'b0111, 32'h00CAFEF0};
        vecs[16] = '{1'b0, 32'h0000_FFFF, 2'd2, 1'b0, 32'h0,        32'hCAFEF00D, 1'b0, 2, 32'hFFFC,    4'b1000, 32'h0,        32'h0,       4'b0111, 32'h0};
        vecs[17] = '{1'b0, 32'h0001_0010, 2'd2, 1'b0, 32'h0,        32'hDE7FBEEF, 1'b0, 1, 32'h10,      4'b1111, 32'h0,        32'h0,       4'b0000, 32'h0};
`endif

        // Reset state with a request pending
        drive(1'b1, 1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
        mem_clr = 1'b1;
        @(posedge clk); #1;
        mem_clr = 1'b0;
        @(negedge clk);
        chk("rst.gnt",    32'(bus.data_gnt_o), 32'd0);
        chk("rst.en",     32'(bus.ram_en_o), 32'd0);
        chk("rst.rvalid", 32'(bus.data_rvalid_o), 32'd0);
        chk("rst.rdata",  bus.data_rdata_o, 32'h0);
        chk("rst.err",    32'(bus.data_err_o), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0);

        for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

        // Back-to-back aligned stores then loads with req held
        for (int ph = 0; ph < 2; ph++) begin
            for (int j = 0; j < 3; j++) begin
                @(posedge clk); #1;
                drive(1'b1, 1'(ph == 0), 32'(4 * j), 2'd2, 1'b0, 32'hA0A0A0A0 + 32'(j));
                @(negedge clk);
                chk($sformatf("b2b%0d.gnt%0d", ph, j), 32'(bus.data_gnt_o), 32'd1);
                if (j > 0) begin
                    chk($sformatf("b2b%0d.rv%0d", ph, j - 1), 32'(bus.data_rvalid_o), 32'd1);
                    chk($sformatf("b2b%0d.rd%0d", ph, j - 1), bus.data_rdata_o,
                        (ph == 1) ? 32'hA0A0A0A0 + 32'(j - 1) : 32'h0);
                end
            end
            @(posedge clk); #1;
            drive(1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0);
            @(negedge clk);
            chk($sformatf("b2b%0d.rv2", ph), 32'(bus.data_rvalid_o), 32'd1);
            chk($sformatf("b2b%0d.rd2", ph), bus.data_rdata_o, (ph == 1) ? 32'hA0A0A0A2 : 32'h0);
            @(negedge clk);
            chk($sformatf("b2b%0d.rvend", ph), 32'(bus.data_rvalid_o), 32'd0);
        end

        // Misaligned load with req held: grant must drop in SECOND
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 32'h21, 2'd2, 1'b0, 32'h0);
        @(negedge clk);
        chk("hold.gnt1", 32'(bus.data_gnt_o), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("hold.gnt2",  32'(bus.data_gnt_o), 32'd0);
        chk("hold.en2",   32'(bus.ram_en_o), 32'd1);
        chk("hold.addr2", 32'(bus.ram_addr_o), 32'h24);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0);
        @(negedge clk);
        chk("hold.rv",    32'(bus.data_rvalid_o), 32'd1);
        chk("hold.rdata", bus.data_rdata_o, 32'h11223344);

        // Reset while in SECOND of a misaligned load
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 32'h21, 2'd2, 1'b0, 32'h0);
        @(negedge clk);
        chk("rsec.gnt", 32'(bus.data_gnt_o), 32'd1);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        chk("rsec.en2", 32'(bus.ram_en_o), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk($sformatf("rsec.norv%0d", k), 32'(bus.data_rvalid_o), 32'd0);
        end
        run_vec(vecs[13], 99);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
